// File: rtl/rx_uart.sv
// UART receiver: 16x oversampled line, majority vote per bit, optional even parity,
// single-entry output register with a valid/ready handshake and one-clk error pulses.
module rx_uart #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter bit PARITY_ENABLED   = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_tick,
  input  logic                        serial_in,
  input  logic                        i_ready,
  output logic [INPUT_DATA_WIDTH-1:0] o_data,
  output logic                        o_valid,
  output logic                        o_busy,
  output logic                        o_parity_err,
  output logic                        o_framing_err,
  output logic                        o_overrun
);

  localparam int IdxW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(INPUT_DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  rxSync_q;
  logic [3:0]                  tickCnt_q, tickCnt_d;
  logic [IdxW-1:0]             bitIdx_q, bitIdx_d;
  logic [INPUT_DATA_WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [INPUT_DATA_WIDTH-1:0] data_q, data_d;
  logic                        sample7_q, sample7_d, sample8_q, sample8_d;
  logic                        parFail_q, parFail_d;
  logic                        valid_q, valid_d;
  logic                        parErr_q, parErr_d, frameErr_q, frameErr_d, overrun_q, overrun_d;
  logic                        rxS, bitMaj;

  assign rxS    = rxSync_q[1];
  assign bitMaj = (sample7_q & sample8_q) | (sample7_q & rxS) | (sample8_q & rxS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxSync_q   <= 2'b11;
      state_q    <= IDLE;
      tickCnt_q  <= '0;
      bitIdx_q   <= '0;
      shiftReg_q <= '0;
      data_q     <= '0;
      sample7_q  <= 1'b1;
      sample8_q  <= 1'b1;
      parFail_q  <= 1'b0;
      valid_q    <= 1'b0;
      parErr_q   <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxSync_q   <= {rxSync_q[0], serial_in};
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      data_q     <= data_d;
      sample7_q  <= sample7_d;
      sample8_q  <= sample8_d;
      parFail_q  <= parFail_d;
      valid_q    <= valid_d;
      parErr_q   <= parErr_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tickCnt_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    data_d     = data_q;
    sample7_d  = sample7_q;
    sample8_d  = sample8_q;
    parFail_d  = parFail_q;
    valid_d    = valid_q;
    parErr_d   = 1'b0;
    frameErr_d = 1'b0;
    overrun_d  = 1'b0;

    if (valid_q && i_ready) valid_d = 1'b0;

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rxS) begin
            state_d   = START;
            tickCnt_d = '0;
            bitIdx_d  = '0;
            parFail_d = 1'b0;
          end
        end
        WAIT_IDLE: begin
          if (rxS) state_d = IDLE;
        end
        default: begin
          tickCnt_d = tickCnt_q + 4'd1;
          if (tickCnt_q == 4'd7) sample7_d = rxS;
          if (tickCnt_q == 4'd8) sample8_d = rxS;
          case (state_q)
            START: begin
              if (tickCnt_q == 4'd9 && bitMaj) state_d = IDLE;
              else if (tickCnt_q == 4'd15)     state_d = DATA;
            end
            DATA: begin
              if (tickCnt_q == 4'd9)
                shiftReg_d = (shiftReg_q >> 1) | (INPUT_DATA_WIDTH'(bitMaj) << (INPUT_DATA_WIDTH - 1));
              if (tickCnt_q == 4'd15) begin
                if (bitIdx_q == LastIdx) state_d = PARITY_ENABLED ? PARITY : STOP;
                else                     bitIdx_d = bitIdx_q + 1'b1;
              end
            end
            PARITY: begin
              if (tickCnt_q == 4'd9)  parFail_d = (^shiftReg_q) ^ bitMaj;
              if (tickCnt_q == 4'd15) state_d = STOP;
            end
            STOP: begin
              // Decide mid-stop-bit so the receiver is re-armed before the next start edge.
              if (tickCnt_q == 4'd9) begin
                if (!bitMaj) begin
                  frameErr_d = 1'b1;
                  state_d    = WAIT_IDLE;
                end else begin
                  state_d = IDLE;
                  if (parFail_q)               parErr_d  = 1'b1;
                  else if (valid_q && !i_ready) overrun_d = 1'b1;
                  else begin
                    data_d  = shiftReg_q;
                    valid_d = 1'b1;
                  end
                end
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_busy        = (state_q != IDLE);
  assign o_parity_err  = parErr_q;
  assign o_framing_err = frameErr_q;
  assign o_overrun     = overrun_q;

endmodule

// File: doc/rx_uart.md
RX_UART -- requirements
Module: rx_uart

Interface
REQ-001 The block SHALL have parameter INPUT_DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 The block SHALL have parameter PARITY_ENABLED, default 1; 1 means one even-parity bit follows the data, 0 means no parity bit.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port sample_tick, input, 1 bit: single-cycle clock enable at 16x the baud rate.
REQ-006 Port serial_in, input, 1 bit: asynchronous line input; idles high.
REQ-007 Port i_ready, input, 1 bit: the consumer accepts o_data when i_ready and o_valid are both high.
REQ-008 Port o_data, output, INPUT_DATA_WIDTH bits: the received data word, LSB received first.
REQ-009 Port o_valid, output, 1 bit: o_data holds an unconsumed word.
REQ-010 Port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 Port o_parity_err, output, 1 bit: one-clk pulse when a frame fails the parity check.
REQ-012 Port o_framing_err, output, 1 bit: one-clk pulse when a stop-bit check fails.
REQ-013 Port o_overrun, output, 1 bit: one-clk pulse when a frame is dropped because o_valid is still high.

Function
REQ-014 serial_in SHALL pass through a 2-FF synchronizer reset to 1; all decisions SHALL use the synchronized value rx_s.
REQ-015 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-016 A 4-bit tick counter SHALL advance only on sample_tick and wrap 15->0; each bit window is 16 ticks.
REQ-017 IDLE: on a sample_tick with rx_s==0, the FSM SHALL go to START with the counter at 0.
REQ-018 Bit value SHALL be the majority of rx_s sampled on ticks 7, 8 and 9 of the window, decided on tick 9.
REQ-019 START: a majority of 1 is a false start, and the FSM SHALL return to IDLE with no flag; a majority of 0 SHALL lead to DATA at the next window.
REQ-020 DATA: bits SHALL shift in LSB first with a bit index 0..INPUT_DATA_WIDTH-1.
REQ-021 After the last data bit, the FSM SHALL go to PARITY if PARITY_ENABLED=1, else to STOP.
REQ-022 PARITY: the XOR of the data bits and the received parity bit SHALL equal 0; a mismatch sets an internal parity-fail flag.
REQ-023 STOP: on tick 9 of the stop window, the FSM SHALL evaluate the frame and return to IDLE within the same clk, so re-arming occurs mid-stop-bit.
REQ-024 Stop majority 0: the FSM SHALL pulse o_framing_err, discard the word, suppress parity and overrun flags, and go to WAIT_IDLE.
REQ-025 WAIT_IDLE: the FSM SHALL go to IDLE on the first sample_tick with rx_s==1, so a break does not retrigger.
REQ-026 Stop OK with parity fail: the FSM SHALL pulse o_parity_err and discard the word.
REQ-027 Stop OK with parity OK: if o_valid==0, o_data SHALL load and o_valid SHALL rise on the next clk; if o_valid==1, the FSM SHALL pulse o_overrun and leave o_data and o_valid unchanged.
REQ-028 o_valid SHALL clear on the clk after (o_valid & i_ready).
REQ-029 When a load and a consume fall in the same clk, the load SHALL win: o_data updates, o_valid stays 1, and no overrun is raised.
REQ-030 Frame-to-o_valid latency SHALL be 1 clk after the stop-bit decision tick.
REQ-031 sample_tick held low SHALL freeze the FSM and counter; error pulses are exactly 1 clk wide.

Reset
REQ-032 When reset goes low, the FSM SHALL enter IDLE, the counter and bit index SHALL clear, and the synchronizer SHALL be set to 1.
REQ-033 When reset goes low, the block SHALL set o_data=0, o_valid=0, o_busy=0 and all error pulses to 0, immediately and regardless of clk.
REQ-034 A reset mid-frame SHALL abandon the frame with no flags; after release, reception SHALL restart only on a new falling edge.

Verification
REQ-035 Scenario: frame 0xA5 with parity 0, stop 1, i_ready=1 -> o_valid pulse with o_data=0xA5 and no error flags.
REQ-036 Scenario: frame 0x37 with parity bit 0 (should be 1) -> o_parity_err pulse, o_valid stays 0.
REQ-037 Scenario: frame 0x55 with stop bit 0, then line held low 3 bit times -> one o_framing_err pulse, no retrigger until the line goes high, then the next frame 0x0F is received correctly.
REQ-038 Scenario: a 6-tick low glitch on an idle line -> false start, return to IDLE, no o_valid and no flags.
REQ-039 Scenario: i_ready=0 while 0x11 then 0x22 are sent -> o_data=0x11 held and an o_overrun pulse at the 0x22 stop decision; raising i_ready clears o_valid.
REQ-040 Scenario: reset asserted mid-DATA of 0xFF -> outputs go to reset values at once, and the next frame 0x3C is received correctly.
